// File: rtl/adder_operand_loader.sv
// Serial-to-parallel operand loader for tt_um_adder: shifts in A then B (MSB first),
// holds the pair and hands it to the adder with a valid/ready handshake.
module adder_operand_loader #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clear,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             ops_valid,
   input  logic             ops_ready,
   output logic             busy,
   output logic             overrun
);

   // state  | meaning
   // LOAD_A | shifting operand A bits into staging register sa
   // LOAD_B | shifting operand B bits into staging register sb
   // HOLD   | complete pair presented, waiting for ops_ready
   typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] sa_shift, sb_shift;

   // shift form also works for WIDTH == 1, where a [WIDTH-2:0] slice would not exist
   assign sa_shift = (sa_q << 1) | WIDTH'(din);
   assign sb_shift = (sb_q << 1) | WIDTH'(din);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= LOAD_A;
         cnt_q     <= '0;
         sa_q      <= '0;
         sb_q      <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      overrun_d = overrun_q;
      if (clear) begin
         state_d   = LOAD_A;
         cnt_d     = '0;
         sa_d      = '0;
         sb_d      = '0;
         op_a_d    = '0;
         op_b_d    = '0;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            LOAD_A: begin
               if (din_valid) begin
                  sa_d = sa_shift;
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     state_d = LOAD_B;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            LOAD_B: begin
               if (din_valid) begin
                  sb_d = sb_shift;
                  if (cnt_q == CNT_LAST) begin
                     op_a_d  = sa_q;
                     op_b_d  = sb_shift;
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            HOLD: begin
               // a bit arriving while the pair is held is lost, even on the handshake edge
               if (din_valid) overrun_d = 1'b1;
               if (ops_ready) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
         endcase
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign ops_valid = (state_q == HOLD);
   assign busy      = (state_q == LOAD_B) || ((state_q == LOAD_A) && (cnt_q != '0));
   assign overrun   = overrun_q;

endmodule
